// File: rtl/mem_fill_pkg.sv
// -----------------------------------------------------------------------------
// mem_fill_pkg
//   Shared types for the memory-fill engine: the fill-pattern selector and the
//   controller state encoding. Imported by mem_fill and mem_fill_pat.
// -----------------------------------------------------------------------------
package mem_fill_pkg;

    // Fill pattern selector, encoded to match the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_IDENT = 2'd0,  // word i holds i
        MODE_CONST = 2'd1,  // every word holds the pattern
        MODE_DESC  = 2'd2,  // word i holds DEPTH-1-i
        MODE_RAMP  = 2'd3   // word i holds pattern+i
    } mode_e;

    // Controller states. READ and DRAIN are only reachable in the verify build.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage : mem_fill_pkg

// File: rtl/mem_fill_pat.sv
// -----------------------------------------------------------------------------
// mem_fill_pat
//   Purely combinational fill-pattern generator. Given the latched mode, the
//   latched pattern byte and a word index, produces the value that word must
//   hold. One instance serves both the write path and the read-back compare.
//
// Ports
//   i_mode    : fill pattern selector
//   i_pattern : constant (MODE_CONST) or start offset (MODE_RAMP)
//   i_idx     : word index, ADDR_W+1 bits wide
//   o_value   : expected word value, reduced modulo 2**DATA_W
// -----------------------------------------------------------------------------
module mem_fill_pat
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
)
(
    input  mode_e              i_mode,
    input  logic [DATA_W-1:0]  i_pattern,
    input  logic [ADDR_W:0]    i_idx,
    output logic [DATA_W-1:0]  o_value
);

    // Arithmetic is carried out wide enough for both operands and then
    // truncated, which is exactly the modulo-2**DATA_W reduction wanted.
    localparam int WIDE_W = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 2) : (DATA_W + 1);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred even if a branch is later removed.
        o_value = i_pattern;
        case (i_mode)
            MODE_IDENT: o_value = DATA_W'(WIDE_W'(i_idx));
            MODE_CONST: o_value = i_pattern;
            MODE_DESC:  o_value = DATA_W'(WIDE_W'(DEPTH - 1) - WIDE_W'(i_idx));
            MODE_RAMP:  o_value = DATA_W'(WIDE_W'(i_pattern) + WIDE_W'(i_idx));
        endcase
    end

endmodule : mem_fill_pat

// File: rtl/mem_fill.sv
// -----------------------------------------------------------------------------
// mem_fill
//   Fills words 0..DEPTH-1 of an external RAM with a selectable pattern, one
//   word per clock. A start request (en) is taken only while idle (rdy=1);
//   mode and pattern are latched at that edge and held for the whole run.
//
//   Build option MEM_FILL_VERIFY_EN: after the write pass the engine reads
//   every word back (registered RAM, one cycle read latency), compares it
//   against the generated value and reports the first mismatching address
//   through the sticky err / err_addr outputs. Without the macro, err and
//   err_addr are tied low and rddata is ignored.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   en       : start request, sampled only while rdy=1
//   rdy      : high when idle and able to accept en
//   mode     : fill pattern (0 ident, 1 const, 2 descending, 3 offset ramp)
//   pattern  : constant value (mode 1) or ramp start (mode 3)
//   addr     : RAM address
//   wrdata   : RAM write data
//   wren     : RAM write enable, high only in WRITE
//   rddata   : RAM read data, valid one cycle after addr
//   err      : sticky verify mismatch flag
//   err_addr : first mismatching address
// -----------------------------------------------------------------------------
module mem_fill
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] pattern,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren,
    input  logic [DATA_W-1:0] rddata,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    // One extra index bit so DEPTH = 2**ADDR_W still has a distinct last index
    // and the counter never wraps before the pass ends.
    localparam int               IDX_W    = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e            r_state;
    state_e            w_next_state;
    mode_e             r_mode;
    logic [DATA_W-1:0] r_pattern;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_pat_idx;
    logic [DATA_W-1:0] w_pat_value;
    logic              w_accept;
    logic              w_last;

    assign w_accept = (r_state == IDLE) && en;
    assign w_last   = (r_idx == LAST_IDX);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                if (w_last) begin
`ifdef MEM_FILL_VERIFY_EN
                    w_next_state = READ;
`else
                    w_next_state = IDLE;
`endif
                end
            end
            READ: begin
                if (w_last) begin
                    w_next_state = DRAIN;
                end
            end
            // DRAIN covers the read latency of the final word.
            DRAIN: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. addr/wrdata are forced to zero outside the pass that uses
    // them, which also gives the required all-zero outputs during reset.
    // ------------------------------------------------------------------------
    always_comb begin
        rdy    = 1'b0;
        wren   = 1'b0;
        addr   = '0;
        wrdata = '0;
        case (r_state)
            IDLE: begin
                rdy = 1'b1;
            end
            WRITE: begin
                wren   = 1'b1;
                addr   = r_idx[ADDR_W-1:0];
                wrdata = w_pat_value;
            end
            READ: begin
                addr = r_idx[ADDR_W-1:0];
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operation parameters and word index. The index restarts at zero at the
    // end of each pass so the read pass walks the same range as the write.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= MODE_IDENT;
            r_pattern <= '0;
            r_idx     <= '0;
        end else if (w_accept) begin
            r_mode    <= mode_e'(mode);
            r_pattern <= pattern;
            r_idx     <= '0;
        end else if ((r_state == WRITE) || (r_state == READ)) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Read-back verify
    // ------------------------------------------------------------------------
`ifdef MEM_FILL_VERIFY_EN
    logic              r_cmp_vld;
    logic [IDX_W-1:0]  r_cmp_idx;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;

    // The address issued in one READ cycle returns data in the next, so the
    // index is delayed one cycle to line up with rddata. The last compare
    // lands in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_vld  <= 1'b0;
            r_cmp_idx  <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_accept) begin
            r_cmp_vld  <= 1'b0;
            r_cmp_idx  <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_cmp_vld <= (r_state == READ);
            r_cmp_idx <= r_idx;
            // Only the first mismatch is recorded; err stays set afterwards.
            if (r_cmp_vld && (rddata != w_pat_value) && !r_err) begin
                r_err      <= 1'b1;
                r_err_addr <= r_cmp_idx[ADDR_W-1:0];
            end
        end
    end

    // Writes and compares never overlap in time, so one generator serves
    // both: the compare index takes over while a compare is pending.
    assign w_pat_idx = r_cmp_vld ? r_cmp_idx : r_idx;
    assign err       = r_err;
    assign err_addr  = r_err_addr;
`else
    logic w_unused_rddata;

    assign w_unused_rddata = ^rddata;
    assign w_pat_idx       = r_idx;
    assign err             = 1'b0;
    assign err_addr        = '0;
`endif

    mem_fill_pat #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_pat (
        .i_mode    (r_mode),
        .i_pattern (r_pattern),
        .i_idx     (w_pat_idx),
        .o_value   (w_pat_value)
    );

endmodule : mem_fill
